// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: sequencer for the 8-channel analog acquisition path.
// It walks the enabled channels in ascending order. For each channel it
// selects the analog mux, waits for settling, pulses CNVST_N, and reads the
// 16-bit result MSB first over SCLK/SDOUT. It then strobes the result out.
module adc_scan_ctrl #(
  parameter int SETTLE_CYC = 200,
  parameter int CONV_CYC   = 160,
  parameter int CLK_DIV    = 4
) (
  input  logic        CLK_100M,
  input  logic        rst_n,
  input  logic [7:0]  ch_en_i,
  input  logic        scan_start_i,
  input  logic        continuous_i,
  output logic        busy_o,
  output logic [7:0]  ad_sel_o,
  output logic        ad_cnvst_n_o,
  output logic        ad_sclk_o,
  input  logic        ad_sdout_i,
  output logic        res_valid_o,
  output logic [2:0]  res_ch_o,
  output logic [15:0] res_data_o,
  output logic        scan_done_o
);

  typedef enum logic [2:0] {
    IDLE, SELECT, PULSE, CONV, SHIFT, STORE, NEXT
  } state_t;

  localparam int PULSE_CYC = 4;
  localparam int CNT_MAX0  = (SETTLE_CYC > CONV_CYC) ? SETTLE_CYC : CONV_CYC;
  localparam int CNT_MAX   = (CNT_MAX0 > PULSE_CYC) ? CNT_MAX0 : PULSE_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DIV_W     = $clog2(CLK_DIV + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic [7:0]        mask_q, mask_d;
  logic [2:0]        ch_q, ch_d;
  logic [14:0]       shift_q, shift_d;
  logic [15:0]       res_data_q, res_data_d;
  logic [2:0]        res_ch_q, res_ch_d;
  logic              sdout_q;
  logic [7:0]        hi_mask;

  // Index of the lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // Enabled channels strictly above the current one.
  assign hi_mask = mask_q & (8'hFE << ch_q);

  // State register.
  always_ff @(posedge CLK_100M or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: counters, channel bookkeeping, shifter and result.
  always_ff @(posedge CLK_100M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      mask_q     <= '0;
      ch_q       <= '0;
      shift_q    <= '0;
      res_data_q <= '0;
      res_ch_q   <= '0;
      sdout_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      shift_q    <= shift_d;
      res_data_q <= res_data_d;
      res_ch_q   <= res_ch_d;
      sdout_q    <= ad_sdout_i;
    end
  end

  // Next-state and datapath update logic for the scan sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    mask_d     = mask_q;
    ch_d       = ch_q;
    shift_d    = shift_q;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
    case (state_q)
      IDLE: begin
        if (scan_start_i && (ch_en_i != 8'd0)) begin
          mask_d  = ch_en_i;
          ch_d    = lowest_bit(ch_en_i);
          cnt_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = CONV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONV: begin
        if (cnt_q == CONV_LAST) begin
          cnt_d   = '0;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            shift_d = {shift_q[13:0], sdout_q};
            if (bit_q == 4'd15) begin
              res_data_d = {shift_q, sdout_q};
              res_ch_d   = ch_q;
              sclk_d     = 1'b0;
              state_d    = STORE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      STORE: begin
        state_d = NEXT;
      end
      NEXT: begin
        cnt_d = '0;
        if (hi_mask != 8'd0) begin
          ch_d    = lowest_bit(hi_mask);
          state_d = SELECT;
        end else if (continuous_i && (ch_en_i != 8'd0)) begin
          mask_d  = ch_en_i;
          ch_d    = lowest_bit(ch_en_i);
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin and status outputs decoded from the current state.
  always_comb begin
    busy_o       = (state_q != IDLE);
    ad_sel_o     = 8'd0;
    ad_cnvst_n_o = 1'b1;
    res_valid_o  = 1'b0;
    scan_done_o  = 1'b0;
    case (state_q)
      SELECT, CONV, SHIFT, STORE: ad_sel_o = 8'd1 << ch_q;
      PULSE: begin
        ad_sel_o     = 8'd1 << ch_q;
        ad_cnvst_n_o = 1'b0;
      end
      NEXT: scan_done_o = (hi_mask == 8'd0);
      default: ;
    endcase
    if (state_q == STORE) res_valid_o = 1'b1;
  end

  assign ad_sclk_o  = sclk_q;
  assign res_ch_o   = res_ch_q;
  assign res_data_o = res_data_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Testbench for adc_scan_ctrl: a serial ADC model plus a scoreboard of the
// results expected for each scan, derived from the channel mask.
module tb_adc_scan_ctrl;

  localparam int SLOT      = 494;
  localparam int FIRST_RES = 493;

  logic        CLK_100M = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ch_en = 8'd0;
  logic        scan_start = 1'b0;
  logic        continuous = 1'b0;
  logic        busy;
  logic [7:0]  ad_sel;
  logic        ad_cnvst_n;
  logic        ad_sclk;
  logic        ad_sdout;
  logic        res_valid;
  logic [2:0]  res_ch;
  logic [15:0] res_data;
  logic        scan_done;

  int checks = 0;
  int errors = 0;

  adc_scan_ctrl dut (
    .CLK_100M     (CLK_100M),
    .rst_n        (rst_n),
    .ch_en_i      (ch_en),
    .scan_start_i (scan_start),
    .continuous_i (continuous),
    .busy_o       (busy),
    .ad_sel_o     (ad_sel),
    .ad_cnvst_n_o (ad_cnvst_n),
    .ad_sclk_o    (ad_sclk),
    .ad_sdout_i   (ad_sdout),
    .res_valid_o  (res_valid),
    .res_ch_o     (res_ch),
    .res_data_o   (res_data),
    .scan_done_o  (scan_done)
  );

  always #5 CLK_100M = ~CLK_100M;

  // Serial ADC model: returns curBase + channel, MSB first, advancing on SCLK falls.
  logic [15:0] curBase = 16'd0;
  logic [15:0] adcWord = 16'd0;
  int          bitIdx = 0;
  logic        prevCnvst = 1'b1;
  logic        prevSclk = 1'b0;

  function automatic logic [2:0] selIndex(input logic [7:0] s);
    selIndex = 3'd0;
    for (int i = 0; i < 8; i++) if (s[i]) selIndex = 3'(i);
  endfunction

  always @(posedge CLK_100M) begin
    prevCnvst <= ad_cnvst_n;
    prevSclk  <= ad_sclk;
    if (prevCnvst && !ad_cnvst_n) begin
      adcWord <= curBase + 16'(selIndex(ad_sel));
      bitIdx  <= 0;
    end else if (prevSclk && !ad_sclk && bitIdx < 16) begin
      bitIdx <= bitIdx + 1;
    end
  end

  always_comb begin
    ad_sdout = 1'b0;
    if (bitIdx < 16) ad_sdout = adcWord[4'(15 - bitIdx)];
  end

  // Monitor sampling DUT outputs on the falling edge.
  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] data;
  } res_t;

  res_t resQ[$];
  int   resCycQ[$];
  res_t expQ[$];
  logic monEn = 1'b0;
  int   busyCycles, doneCount, doneCycle, selZero, cnvstLow, oneHotErr;

  always @(negedge CLK_100M) begin
    if (monEn) begin
      res_t r;
      if (busy) busyCycles++;
      if (res_valid) begin
        r.ch   = res_ch;
        r.data = res_data;
        resQ.push_back(r);
        resCycQ.push_back(busyCycles);
      end
      if (scan_done) begin
        doneCount++;
        doneCycle = busyCycles;
      end
      if (busy && ad_sel == 8'd0) selZero++;
      if (!ad_cnvst_n) cnvstLow++;
      if (ad_sel != 8'd0 && !$onehot(ad_sel)) oneHotErr++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: one result per enabled channel, lowest channel first.
  task automatic buildExpected(input logic [7:0] m, input logic [15:0] b);
    res_t r;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        r.ch   = 3'(c);
        r.data = b + 16'(c);
        expQ.push_back(r);
      end
    end
  endtask

  task automatic clearMonitor();
    resQ.delete();
    resCycQ.delete();
    busyCycles = 0;
    doneCount  = 0;
    doneCycle  = 0;
    selZero    = 0;
    cnvstLow   = 0;
    oneHotErr  = 0;
    monEn      = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [15:0] b,
                               input logic cont);
    clearMonitor();
    @(posedge CLK_100M);
    #1;
    ch_en      = m;
    curBase    = b;
    continuous = cont;
    scan_start = 1'b1;
    @(posedge CLK_100M);
    #1;
    scan_start = 1'b0;
  endtask

  task automatic waitBusyCycles(input int target);
    int guard = 0;
    while (busyCycles < target && guard < 20000) begin
      @(negedge CLK_100M);
      guard++;
    end
    if (guard >= 20000) checkOutput("wait_busy_timeout", 32'(busyCycles), 32'(target));
  endtask

  task automatic waitIdle();
    int guard = 0;
    repeat (3) @(negedge CLK_100M);
    while (busy && guard < 40000) begin
      @(negedge CLK_100M);
      guard++;
    end
    if (guard >= 40000) checkOutput("idle_timeout", 32'(busy), 32'd0);
    repeat (3) @(negedge CLK_100M);
  endtask

  task automatic compareScan(input string tag, input int expDone);
    int n;
    n = expQ.size();
    checkOutput({tag, "_count"}, 32'(resQ.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < resQ.size()) begin
        checkOutput($sformatf("%s_ch%0d", tag, i), 32'(resQ[i].ch), 32'(expQ[i].ch));
        checkOutput($sformatf("%s_data%0d", tag, i), 32'(resQ[i].data), 32'(expQ[i].data));
      end
    end
    checkOutput({tag, "_done"}, 32'(doneCount), 32'(expDone));
    checkOutput({tag, "_busy"}, 32'(busyCycles), 32'(n * SLOT));
    checkOutput({tag, "_selzero"}, 32'(selZero), 32'(n));
    checkOutput({tag, "_cnvst"}, 32'(cnvstLow), 32'(n * 4));
    checkOutput({tag, "_onehot"}, 32'(oneHotErr), 32'd0);
    if (n > 0 && resCycQ.size() > 0) begin
      checkOutput({tag, "_first_res"}, 32'(resCycQ[0]), 32'(FIRST_RES));
      checkOutput({tag, "_done_after_last"}, 32'(doneCycle),
                  32'(resCycQ[resCycQ.size() - 1] + 1));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ad_sel"}, 32'(ad_sel), 32'd0);
    checkOutput({tag, "_cnvst_n"}, 32'(ad_cnvst_n), 32'd1);
    checkOutput({tag, "_sclk"}, 32'(ad_sclk), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_res_ch"}, 32'(res_ch), 32'd0);
    checkOutput({tag, "_res_data"}, 32'(res_data), 32'd0);
    checkOutput({tag, "_scan_done"}, 32'(scan_done), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  chEn;
    logic [15:0] base;
    int          expCount;
    int          expDone;
  } vec_t;

  vec_t vecs[6];

  initial begin
    res_t r;
    vecs[0] = '{chEn: 8'h01, base: 16'hA5C3, expCount: 1, expDone: 1};
    vecs[1] = '{chEn: 8'h85, base: 16'h1000, expCount: 3, expDone: 1};
    vecs[2] = '{chEn: 8'h00, base: 16'h7777, expCount: 0, expDone: 0};
    for (int i = 3; i < 6; i++) begin
      vecs[i].chEn     = 8'($urandom_range(1, 255));
      vecs[i].base     = 16'($urandom);
      vecs[i].expCount = $countones(vecs[i].chEn);
      vecs[i].expDone  = 1;
    end

    repeat (4) @(posedge CLK_100M);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge CLK_100M);

    // Single scans from the vector table.
    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      expQ.delete();
      buildExpected(vecs[v].chEn, vecs[v].base);
      checkOutput({tag, "_model_count"}, 32'(expQ.size()), 32'(vecs[v].expCount));
      applyStimulus(vecs[v].chEn, vecs[v].base, 1'b0);
      waitIdle();
      compareScan(tag, vecs[v].expDone);
    end

    // Continuous mode, dropped during channel 0 of the second scan.
    expQ.delete();
    buildExpected(8'h03, 16'h3000);
    buildExpected(8'h03, 16'h3000);
    applyStimulus(8'h03, 16'h3000, 1'b1);
    waitBusyCycles(2 * SLOT + 50);
    continuous = 1'b0;
    waitIdle();
    compareScan("cont", 2);

    // scan_start during CONV of the first slot is ignored.
    expQ.delete();
    buildExpected(8'h85, 16'h2000);
    applyStimulus(8'h85, 16'h2000, 1'b0);
    waitBusyCycles(300);
    @(posedge CLK_100M);
    #1;
    scan_start = 1'b1;
    ch_en      = 8'hFF;
    @(posedge CLK_100M);
    #1;
    scan_start = 1'b0;
    waitIdle();
    compareScan("conv_start", 1);

    // Asynchronous reset in the middle of SHIFT.
    applyStimulus(8'h01, 16'h4321, 1'b0);
    waitBusyCycles(420);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midshift");
    @(posedge CLK_100M);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge CLK_100M);

    expQ.delete();
    buildExpected(8'h10, 16'h5A00);
    applyStimulus(8'h10, 16'h5A00, 1'b0);
    waitIdle();
    compareScan("post_reset", 1);
    r = expQ[0];
    checkOutput("post_reset_hold_data", 32'(res_data), 32'(r.data));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
